// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- registered next-program-counter generator.
//
// Every rising clk_i edge, the unit loads one new PC value into a register.
// The value is chosen from the current PC (pc_i) and the control inputs, in
// this order of priority:
//   rst_i     : 0
//   start_i   : startadd_i
//   branchf_i : pc_i + target_i + 1
//   branchb_i : pc_i - target_i + 1
//   otherwise : pc_i + 1
// All arithmetic wraps modulo 2^AW. There is no flag for overflow or underflow.
// There is no handshake and no stall: the register updates on every edge.
//
// Ports
//   clk_i       in   1   clock; all state changes on its rising edge
//   rst_i       in   1   synchronous active-high reset (pc_o -> 0)
//   pc_i        in   AW  current PC, the base for next-PC arithmetic
//   start_i     in   1   load startadd_i
//   startadd_i  in   AW  start address
//   branchf_i   in   1   forward branch by target_i
//   branchb_i   in   1   backward branch by target_i
//   target_i    in   AW  unsigned branch offset
//   pc_o        out  AW  registered next PC (driven straight from a flop)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] pc_i,
  input  logic          start_i,
  input  logic [AW-1:0] startadd_i,
  input  logic          branchf_i,
  input  logic          branchb_i,
  input  logic [AW-1:0] target_i,
  output logic [AW-1:0] pc_o
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] fwd_pc;
  logic [AW-1:0] bwd_pc;
  logic [AW-1:0] inc_pc;

  // Candidate next PCs. Each result is truncated to AW bits, so wrap-around
  // happens with no extra logic.
  assign fwd_pc = pc_i + target_i + ONE;
  assign bwd_pc = pc_i - target_i + ONE;
  assign inc_pc = pc_i + ONE;

  // Next-PC selection. Start has the highest priority. A forward branch beats
  // a backward branch when both are asserted.
  always_comb begin
    pc_next = inc_pc;
    if (start_i) begin
      pc_next = startadd_i;
    end else if (branchf_i) begin
      pc_next = fwd_pc;
    end else if (branchb_i) begin
      pc_next = bwd_pc;
    end
  end

  // Reset overrides every other input on the edge where it is sampled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc_o = pc_reg;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit (AW = 8).
//
// Inputs are driven on the falling edge. pc_o is sampled 1 ns after the rising
// edge. Expected values come from a plain-integer reference model of the
// next-PC rules.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam int AW = 8;
  localparam int MOD = 1 << AW;

  logic          clk;
  logic          rst_i;
  logic [AW-1:0] pc_i;
  logic          start_i;
  logic [AW-1:0] startadd_i;
  logic          branchf_i;
  logic          branchb_i;
  logic [AW-1:0] target_i;
  logic [AW-1:0] pc_o;

  int checks;
  int failures;

  pc_unit #(.AW(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .pc_i       (pc_i),
    .start_i    (start_i),
    .startadd_i (startadd_i),
    .branchf_i  (branchf_i),
    .branchb_i  (branchb_i),
    .target_i   (target_i),
    .pc_o       (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the selection rules evaluated with integer arithmetic,
  // then reduced modulo 2^AW.
  function automatic logic [AW-1:0] model_next(
    input int rst, input int st, input int sa,
    input int bf, input int bb, input int pc, input int tg);
    int r;
    if (rst != 0)     r = 0;
    else if (st != 0) r = sa;
    else if (bf != 0) r = pc + tg + 1;
    else if (bb != 0) r = pc - tg + 1;
    else              r = pc + 1;
    r = ((r % MOD) + MOD) % MOD;
    return r[AW-1:0];
  endfunction

  // Drive one set of inputs, let one rising edge pass, and sample just after it.
  task automatic step(input logic rst, input logic st, input logic [AW-1:0] sa,
                      input logic bf, input logic bb, input logic [AW-1:0] pc,
                      input logic [AW-1:0] tg);
    @(negedge clk);
    rst_i = rst; start_i = st; startadd_i = sa;
    branchf_i = bf; branchb_i = bb; pc_i = pc; target_i = tg;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] model_of_inputs();
    return model_next(int'(rst_i), int'(start_i), int'(startadd_i),
                      int'(branchf_i), int'(branchb_i), int'(pc_i), int'(target_i));
  endfunction

  task automatic test_reset();
    logic [AW-1:0] exp;
    step(1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 8'h55, 8'h11);
    exp = 8'h00;
    checks++;
    if (pc_o !== exp) begin
      failures++;
      $display("FAIL reset_over_all got=%h exp=%h", pc_o, exp);
    end
    $display("txn reset rst=1 start=1 startadd=be -> pc_o=%h", pc_o);
    // Reset must hold pc_o at 0 for as long as it stays asserted.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
      checks++;
      if (pc_o !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=00", pc_o);
      end
      $display("txn reset_hold cycle=%0d -> pc_o=%h", i, pc_o);
    end
    // The first edge with rst_i=0 resumes normal selection immediately.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 8'h00);
    checks++;
    if (pc_o !== 8'h42) begin
      failures++;
      $display("FAIL reset_release got=%h exp=42", pc_o);
    end
    $display("txn reset_release pc_i=41 -> pc_o=%h", pc_o);
  endtask

  task automatic test_start();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hBE, 8'h33);
    checks++;
    if (pc_o !== 8'h00) begin
      failures++;
      $display("FAIL start_load got=%h exp=00", pc_o);
    end
    $display("txn start startadd=00 pc_i=be -> pc_o=%h", pc_o);
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h12, 8'h00);
    checks++;
    if (pc_o !== 8'hC3) begin
      failures++;
      $display("FAIL start_load2 got=%h exp=c3", pc_o);
    end
    $display("txn start startadd=c3 -> pc_o=%h", pc_o);
  endtask

  task automatic test_forward();
    step(1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 8'h29);
    checks++;
    if (pc_o !== 8'h2A) begin
      failures++;
      $display("FAIL fwd_basic got=%h exp=2a", pc_o);
    end
    $display("txn fwd pc_i=00 target=29 -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 8'hFE);
    checks++;
    if (pc_o !== 8'hFF) begin
      failures++;
      $display("FAIL fwd_top got=%h exp=ff", pc_o);
    end
    $display("txn fwd pc_i=00 target=fe -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF0, 8'h20);
    checks++;
    if (pc_o !== 8'h11) begin
      failures++;
      $display("FAIL fwd_wrap got=%h exp=11", pc_o);
    end
    $display("txn fwd pc_i=f0 target=20 -> pc_o=%h", pc_o);
  endtask

  task automatic test_backward();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h2A, 8'h05);
    checks++;
    if (pc_o !== 8'h26) begin
      failures++;
      $display("FAIL bwd_basic got=%h exp=26", pc_o);
    end
    $display("txn bwd pc_i=2a target=05 -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFE, 8'hFF);
    checks++;
    if (pc_o !== 8'h00) begin
      failures++;
      $display("FAIL bwd_wrap got=%h exp=00", pc_o);
    end
    $display("txn bwd pc_i=fe target=ff -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h10);
    checks++;
    if (pc_o !== 8'hF4) begin
      failures++;
      $display("FAIL bwd_under got=%h exp=f4", pc_o);
    end
    $display("txn bwd pc_i=03 target=10 -> pc_o=%h", pc_o);
  endtask

  task automatic test_increment();
    step(1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h26, 8'h55);
    checks++;
    if (pc_o !== 8'h27) begin
      failures++;
      $display("FAIL inc_basic got=%h exp=27", pc_o);
    end
    $display("txn inc pc_i=26 -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'hFF, 8'h55);
    checks++;
    if (pc_o !== 8'h00) begin
      failures++;
      $display("FAIL inc_wrap got=%h exp=00", pc_o);
    end
    $display("txn inc pc_i=ff -> pc_o=%h", pc_o);
  endtask

  task automatic test_priority();
    step(1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h80, 8'h07);
    checks++;
    if (pc_o !== 8'h10) begin
      failures++;
      $display("FAIL prio_start got=%h exp=10", pc_o);
    end
    $display("txn prio start+f+b startadd=10 -> pc_o=%h", pc_o);
    step(1'b0, 1'b0, 8'h99, 1'b1, 1'b1, 8'h10, 8'h02);
    checks++;
    if (pc_o !== 8'h13) begin
      failures++;
      $display("FAIL prio_fwd got=%h exp=13", pc_o);
    end
    $display("txn prio f+b pc_i=10 target=02 -> pc_o=%h", pc_o);
    // Reset asserted in the middle of a sequence overrides a pending branch.
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 8'h10, 8'h02);
    checks++;
    if (pc_o !== 8'h00) begin
      failures++;
      $display("FAIL prio_rst_mid got=%h exp=00", pc_o);
    end
    $display("txn prio rst+fwd -> pc_o=%h", pc_o);
  endtask

  task automatic test_back_to_back();
    // Feed pc_o back as pc_i, as a real fetch loop would. The model follows
    // the same chain.
    logic [AW-1:0] exp;
    logic [AW-1:0] cur;
    cur = pc_o;
    for (int i = 0; i < 200; i++) begin
      logic r, s, f, b;
      logic [AW-1:0] sa, tg;
      r  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 2) == 0);
      sa = 8'($urandom);
      tg = 8'($urandom);
      step(r, s, sa, f, b, cur, tg);
      exp = model_next(int'(r), int'(s), int'(sa), int'(f), int'(b), int'(cur), int'(tg));
      checks++;
      if (pc_o !== exp) begin
        failures++;
        $display("FAIL rand_seq i=%0d rst=%b st=%b sa=%h f=%b b=%b pc=%h tg=%h got=%h exp=%h",
                 i, r, s, sa, f, b, cur, tg, pc_o, exp);
      end
      $display("txn rand i=%0d rst=%b st=%b sa=%h f=%b b=%b pc=%h tg=%h -> pc_o=%h",
               i, r, s, sa, f, b, cur, tg, pc_o);
      cur = pc_o;
    end
  endtask

  task automatic test_random_independent();
    // Uncorrelated random inputs, one check per cycle.
    logic [AW-1:0] exp;
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      exp = model_of_inputs();
      checks++;
      if (pc_o !== exp) begin
        failures++;
        $display("FAIL rand_ind i=%0d got=%h exp=%h", i, pc_o, exp);
      end
      $display("txn rand_ind i=%0d -> pc_o=%h", i, pc_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b1; start_i = 1'b0; startadd_i = '0;
    branchf_i = 1'b0; branchb_i = 1'b0; pc_i = '0; target_i = '0;
    test_reset();
    test_start();
    test_forward();
    test_backward();
    test_increment();
    test_priority();
    test_back_to_back();
    test_random_independent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: AW, default 8, PC/address width in bits.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 pc_i  input  AW  current PC value, used as the base for next-PC arithmetic.
REQ-006 start_i  input  1  load the start address.
REQ-007 startadd_i  input  AW  start address.
REQ-008 branchf_i  input  1  branch forward.
REQ-009 branchb_i  input  1  branch backward.
REQ-010 target_i  input  AW  unsigned branch offset.
REQ-011 pc_o  output  AW  registered next PC.

Function
REQ-012 pc_o SHALL be driven directly by a register, with no combinational path from any input to pc_o.
REQ-013 At each rising clk_i edge with rst_i=0, the register SHALL load next, which is selected by priority as follows:
- start_i=1: startadd_i
- else branchf_i=1: pc_i + target_i + 1
- else branchb_i=1: pc_i - target_i + 1
- else: pc_i + 1
REQ-014 All arithmetic SHALL be unsigned modulo 2^AW, wrapping silently with no overflow or underflow flag.
REQ-015 Latency SHALL be exactly one cycle: the inputs sampled at edge N appear on pc_o after edge N and hold until edge N+1.
REQ-016 When branchf_i and branchb_i are both 1 with start_i=0, forward SHALL win; when start_i=1, startadd_i SHALL win regardless of the branch inputs.
REQ-017 target_i SHALL be ignored when no branch is selected, and startadd_i SHALL be ignored when start_i=0.
REQ-018 There SHALL be no handshake and no stall: the register updates every cycle.
REQ-019 X-free inputs SHALL always produce a defined pc_o; there are no illegal input combinations.

Reset
REQ-020 When rst_i=1 at a rising edge, pc_o SHALL become 0 regardless of every other input.
REQ-021 Reset SHALL have priority over start_i and both branch inputs.
REQ-022 pc_o SHALL keep its reset value 0 until the first edge with rst_i=0.
REQ-023 Deasserting rst_i SHALL cause normal next-PC selection to resume at the next edge, with no extra idle cycle.
REQ-024 Asserting rst_i mid-sequence SHALL override any pending branch or start on that edge.

Verification
REQ-025 Reset: rst_i=1, start_i=1, startadd_i=0xBE -> pc_o=0x00 after the edge.
REQ-026 Start load: start_i=1, startadd_i=0x00, pc_i=0xBE -> pc_o=0x00.
REQ-027 Forward branch:
- pc_i=0x00, branchf_i=1, target_i=0x29 -> pc_o=0x2A
- pc_i=0x00, target_i=0xFE -> pc_o=0xFF
REQ-028 Backward branch:
- pc_i=0x2A, branchb_i=1, target_i=0x05 -> pc_o=0x26
- pc_i=0xFE, target_i=0xFF -> pc_o=0x00 (wrap)
REQ-029 Increment:
- pc_i=0x26, all controls 0 -> pc_o=0x27
- pc_i=0xFF -> pc_o=0x00
REQ-030 Priority:
- start_i=branchf_i=branchb_i=1, startadd_i=0x10 -> pc_o=0x10
- branchf_i=branchb_i=1, pc_i=0x10, target_i=0x02 -> pc_o=0x13
